// File: rtl/apx_int_pkg.sv
// Shared definitions for the approximate integer add/sub/accumulate pipeline:
// operation mode encodings and the width of the gated-bit-count field.
package apx_int_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_RSV = 2'b11
    } apx_mode_e;

    // Width of a field able to hold a gated LSB count in 0..g_max.
    function automatic int gated_width(input int g_max);
        return (g_max < 1) ? 1 : $clog2(g_max + 1);
    endfunction

endpackage

// File: rtl/apx_int_addsub_masked.sv
// Combinational masked adder/subtractor/accumulator. The low 'gated' bits of
// every operand are forced to zero, so those result bits come out as zero and
// the upper bits are exact for the selected mode.
module apx_int_addsub_masked
    import apx_int_pkg::*;
#(
    parameter int W = 32,
    parameter int G = 16
) (
    input  logic [W-1:0]                op_a,
    input  logic [W-1:0]                op_b,
    input  logic [W-1:0]                acc,
    input  logic [gated_width(G)-1:0]   gated,
    input  apx_mode_e                   mode,
    output logic [W-1:0]                res,
    output logic                        carry
);

    logic [W-1:0] keep_s;
    logic [W-1:0] a_m_s;
    logic [W-1:0] b_m_s;
    logic [W:0]   sum_s;
    logic [W:0]   diff_s;
    logic [W:0]   acc_sum_s;

    // Build the keep mask (1 for exact bits) and zero the gated adder inputs.
    always_comb begin
        keep_s = '0;
        for (int i = 0; i < W; i++) begin
            keep_s[i] = (i >= int'(gated));
        end
        a_m_s     = op_a & keep_s;
        b_m_s     = op_b & keep_s;
        sum_s     = {1'b0, a_m_s} + {1'b0, b_m_s};
        diff_s    = {1'b0, a_m_s} - {1'b0, b_m_s};
        acc_sum_s = {1'b0, acc} + {1'b0, a_m_s};
    end

    // Select the result for the mode; SUB reports carry as "no borrow".
    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (mode)
            MODE_SUB: begin
                res   = diff_s[W-1:0];
                carry = ~diff_s[W];
            end
            MODE_ACC: begin
                res   = acc_sum_s[W-1:0];
                carry = acc_sum_s[W];
            end
            default: begin
                res   = sum_s[W-1:0];
                carry = sum_s[W];
            end
        endcase
    end

endmodule

// File: rtl/apx_int_add_cfg_pipe.sv
// Two-stage valid/ready pipeline around a configurable approximate adder.
// S1 holds operands plus the config snapshot for that operation, S2 holds the
// result. Gated LSB operand flops are not loaded, cutting switching activity.
module apx_int_add_cfg_pipe
    import apx_int_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int MAX_GATED_BITWIDTH = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_we,
    input  logic [gated_width(MAX_GATED_BITWIDTH)-1:0]   cfg_gated_bits,
    input  logic [1:0]                                   cfg_mode,
    output logic                                         cfg_err,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]                a,
    input  logic [DATA_PATH_BITWIDTH-1:0]                b,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0]                c,
    output logic                                         c_carry,
    output logic                                         busy
);

    localparam int W  = DATA_PATH_BITWIDTH;
    localparam int G  = MAX_GATED_BITWIDTH;
    localparam int GW = gated_width(G);
    localparam logic [GW-1:0] G_MAX = GW'(G);

    // Active configuration
    logic [GW-1:0] cfg_g_r;
    apx_mode_e     cfg_mode_r;
    logic          cfg_err_r;

    // Stage 1: operands and per-operation config snapshot
    logic          s1_valid_r;
    logic [W-1:0]  s1_a_r;
    logic [W-1:0]  s1_b_r;
    logic [GW-1:0] s1_g_r;
    apx_mode_e     s1_mode_r;

    // Stage 2: result
    logic          s2_valid_r;
    logic [W-1:0]  c_r;
    logic          c_carry_r;
    logic [W-1:0]  acc_r;

    logic          s1_adv_s;
    logic          in_ready_s;
    logic          in_fire_s;
    logic          busy_s;
    logic          cfg_ok_s;
    logic [GW-1:0] cfg_g_clamp_s;
    logic [W-1:0]  load_keep_s;
    logic [W-1:0]  res_s;
    logic          carry_s;

    // Handshake, config acceptance and the S1 load-enable mask.
    always_comb begin
        s1_adv_s      = s1_valid_r & (~s2_valid_r | out_ready);
        in_ready_s    = ~rst & (~s1_valid_r | s1_adv_s);
        in_fire_s     = in_valid & in_ready_s;
        busy_s        = s1_valid_r | s2_valid_r;
        cfg_ok_s      = cfg_we & ~busy_s & ~in_valid;
        cfg_g_clamp_s = (cfg_gated_bits > G_MAX) ? G_MAX : cfg_gated_bits;
        load_keep_s   = '0;
        for (int i = 0; i < W; i++) begin
            load_keep_s[i] = (i >= int'(cfg_g_r));
        end
    end

    // Config register: writes land only while idle; rejected writes flag an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_g_r    <= '0;
            cfg_mode_r <= MODE_ADD;
            cfg_err_r  <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we & ~cfg_ok_s;
            if (cfg_ok_s) begin
                cfg_g_r    <= cfg_g_clamp_s;
                cfg_mode_r <= apx_mode_e'(cfg_mode);
            end
        end
    end

    // Stage 1: load ungated operand bits and the config snapshot on input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_g_r     <= '0;
            s1_mode_r  <= MODE_ADD;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= (a & load_keep_s) | (s1_a_r & ~load_keep_s);
            s1_b_r     <= (b & load_keep_s) | (s1_b_r & ~load_keep_s);
            s1_g_r     <= cfg_g_r;
            s1_mode_r  <= cfg_mode_r;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    apx_int_addsub_masked #(
        .W (W),
        .G (G)
    ) u_addsub (
        .op_a  (s1_a_r),
        .op_b  (s1_b_r),
        .acc   (acc_r),
        .gated (s1_g_r),
        .mode  (s1_mode_r),
        .res   (res_s),
        .carry (carry_s)
    );

    // Stage 2: capture the result when S1 advances, drop it once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            c_r        <= '0;
            c_carry_r  <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
            c_r        <= res_s;
            c_carry_r  <= carry_s;
        end else if (out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Accumulator: cleared by an accepted config write, updated on ACC results.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (cfg_ok_s) begin
            acc_r <= '0;
        end else if (s1_adv_s && (s1_mode_r == MODE_ACC)) begin
            acc_r <= res_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign cfg_err   = cfg_err_r;
    assign out_valid = s2_valid_r;
    assign c         = c_r;
    assign c_carry   = c_carry_r;

endmodule

// File: tb/tb_apx_int_add_cfg_pipe.sv
// Directed, table-driven bench for apx_int_add_cfg_pipe (W=32, G=16).
module tb_apx_int_add_cfg_pipe;

    localparam int W  = 32;
    localparam int G  = 16;
    localparam int GW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [GW-1:0] cfg_gated_bits = '0;
    logic [1:0]    cfg_mode = 2'b00;
    logic          cfg_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  c;
    logic          c_carry;
    logic          busy;

    int checks = 0;
    int failures = 0;

    apx_int_add_cfg_pipe #(
        .DATA_PATH_BITWIDTH (W),
        .MAX_GATED_BITWIDTH (G)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_gated_bits (cfg_gated_bits),
        .cfg_mode       (cfg_mode),
        .cfg_err        (cfg_err),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .c              (c),
        .c_carry        (c_carry),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [GW-1:0] g;
        logic [1:0]    mode;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  exp_c;
        logic          exp_carry;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [GW-1:0] g, input logic [1:0] mode);
        cfg_gated_bits = g;
        cfg_mode       = mode;
        cfg_we         = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("cfg_accept_no_err", 32'(cfg_err), 32'd0);
    endtask

    // Single operation with out_ready high: result visible after the second edge.
    task automatic do_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp_c, input logic exp_carry);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_c"}, c, exp_c);
        chk({name, "_carry"}, 32'(c_carry), 32'(exp_carry));
        tick();
    endtask

    function automatic logic [W-1:0] stream_a(input int i);
        return 32'(i) * 32'h1111_1111;
    endfunction

    function automatic logic [W-1:0] stream_b(input int i);
        return 32'hF000_0000 + 32'(i);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;

        // {g, mode, a, b, expected c, expected carry}
        vecs[0] = '{5'd0,  2'b00, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
        vecs[1] = '{5'd16, 2'b00, 32'h1234_ABCD, 32'h0001_FFFF, 32'h1235_0000, 1'b0};
        vecs[2] = '{5'd4,  2'b01, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 1'b0};
        vecs[3] = '{5'd0,  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[4] = '{5'd0,  2'b01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[5] = '{5'd8,  2'b01, 32'h1234_5678, 32'h0000_0178, 32'h1234_5500, 1'b1};
        vecs[6] = '{5'd31, 2'b00, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[7] = '{5'd0,  2'b11, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0};
        vecs[8] = '{5'd16, 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_carry", 32'(c_carry), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Table-driven single operations
        for (int i = 0; i < 9; i++) begin
            cfg_write(vecs[i].g, vecs[i].mode);
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_c, vecs[i].exp_carry);
        end

        // Accumulate 5, 7, 0xFFFFFFFF then a fresh config write clears acc
        cfg_write(5'd0, 2'b10);
        do_op("acc0", 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0005, 1'b0);
        do_op("acc1", 32'h0000_0007, 32'h1234_5678, 32'h0000_000C, 1'b0);
        do_op("acc2", 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000B, 1'b1);
        cfg_write(5'd0, 2'b10);
        do_op("acc_clr", 32'h0000_0003, 32'h0000_0009, 32'h0000_0003, 1'b0);

        // Config writes rejected while in_valid or busy; config stays g=0 ADD
        cfg_write(5'd0, 2'b00);
        in_valid       = 1'b1;
        a              = 32'h0000_0001;
        b              = 32'h0000_0002;
        cfg_we         = 1'b1;
        cfg_mode       = 2'b01;
        cfg_gated_bits = 5'd8;
        tick();
        in_valid = 1'b0;
        chk("err_in_valid", 32'(cfg_err), 32'd1);
        chk("err_busy_flag", 32'(busy), 32'd1);
        tick();
        cfg_we = 1'b0;
        chk("err_busy", 32'(cfg_err), 32'd1);
        chk("err_op_valid", 32'(out_valid), 32'd1);
        chk("err_op_c", c, 32'h0000_0003);
        tick();
        chk("err_pulse_end", 32'(cfg_err), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        do_op("cfg_kept", 32'h0000_01FF, 32'h0000_0001, 32'h0000_0200, 1'b0);

        // Stream of 20 operations with out_ready toggling 1,0,1,0...
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
            in_valid  = (sent < 20);
            a         = stream_a(sent);
            b         = stream_b(sent);
            out_ready = ((cyc % 2) == 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk($sformatf("stream_c%0d", rcv), c, stream_a(rcv) + stream_b(rcv));
                rcv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(rcv), 32'd20);
        tick();
        chk("stream_no_dup", 32'(out_valid), 32'd0);
        chk("stream_idle", 32'(busy), 32'd0);

        // Reset in the middle of a stalled stream
        cfg_write(5'd8, 2'b01);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 32'h0000_1000;
        b         = 32'h0000_0100;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("mid_rst_quiet%0d", k), 32'(out_valid), 32'd0);
        end
        chk("mid_rst_busy", 32'(busy), 32'd0);
        do_op("rst_cfg_default", 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apx_int_add_cfg_pipe.md
APX_INT_ADD_CFG_PIPE -- requirements
Module: apx_int_add_cfg_pipe

Interface
REQ-001 SHALL have parameter DATA_PATH_BITWIDTH, default 32, datapath width W.
REQ-002 SHALL have parameter MAX_GATED_BITWIDTH, default 16, largest approximable LSB count G (1..W-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_gated_bits  input  clog2(G+1)  requested gated LSB count; values >G clamp to G.
REQ-007 SHALL have port cfg_mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 reserved (treated as ADD).
REQ-008 SHALL have port cfg_err  output  1  one-cycle pulse: config write rejected.
REQ-009 SHALL have ports in_valid input 1, in_ready output 1, a input W, b input W  operand handshake.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, c output W, c_carry output 1  result handshake.
REQ-011 SHALL have port busy  output 1  high while any pipeline stage holds valid data.

Function
REQ-012 Transfers SHALL occur only when valid and ready are both high on a rising edge.
REQ-013 Pipeline SHALL be two stages: S1 operand registers, S2 result register; latency from input to output transfer is 2 cycles with out_ready held high.
REQ-014 Throughput SHALL be one operation per cycle under no backpressure; in_ready = !S1_full || (S1 advances this cycle).
REQ-015 S1 SHALL advance when S2 is empty or S2 drains the same cycle; data SHALL never be dropped or duplicated under backpressure.
REQ-016 With active gated count g: S1 operand flops for bits [g-1:0] SHALL NOT be enabled (hold previous value) and adder inputs for bits [g-1:0] SHALL be forced to zero.
REQ-017 Result bits [g-1:0] SHALL be 0; bits [W-1:g] SHALL be exact for the mode on operand bits [W-1:g].
REQ-018 ADD: c = (a + b) mod 2^W on ungated bits; c_carry = carry out of bit W-1.
REQ-019 SUB: c = (a - b) mod 2^W on ungated bits; c_carry = 1 when no borrow (a_hi >= b_hi unsigned).
REQ-020 ACC: internal accumulator acc (W bits) updates acc <= acc + a_masked on S2 load; c = new acc; c_carry = carry out; b ignored; wraps modulo 2^W.
REQ-021 Active config (g, mode) SHALL be latched per operation at S1 load and travel with it.
REQ-022 cfg_we SHALL be accepted only when busy=0 and in_valid=0; accepted write updates config next cycle and clears acc to 0.
REQ-023 cfg_we while busy=1 or in_valid=1 SHALL be ignored and pulse cfg_err for one cycle the following cycle.
REQ-024 g=0 SHALL give fully exact arithmetic.

Reset
REQ-025 On rst: out_valid=0, c=0, c_carry=0, cfg_err=0, busy=0, acc=0, S1/S2 valid=0, g=0, mode=ADD; in_ready=0 during reset, 1 the cycle after.
REQ-026 rst mid-operation SHALL discard in-flight data with no out_valid pulse afterward.

Structure
REQ-027 Mode encodings and the width function for cfg_gated_bits SHALL reside in shared package apx_int_pkg.
REQ-028 Masked adder/subtractor SHALL be one sub-module apx_int_addsub_masked (combinational, parameter W, G).

Verification
REQ-029 W=32, g=0, ADD, a=0x0000_FFFF, b=0x0000_0001 -> c=0x0001_0000, c_carry=0, two cycles after input transfer.
REQ-030 g=16, ADD, a=0x1234_ABCD, b=0x0001_FFFF -> c=0x1235_0000, c_carry=0.
REQ-031 g=4, SUB, a=0x10, b=0x20 -> c=0xFFFF_FFF0, c_carry=0.
REQ-032 g=0, ACC, three inputs a=5,7,0xFFFF_FFFF -> c=5,12,11; last c_carry=1; subsequent accepted cfg_we clears acc.
REQ-033 Stream 20 ops, out_ready toggling 1010..., -> all 20 results in order, none lost or repeated.
REQ-034 cfg_we with busy=1 -> cfg_err pulses, config unchanged; rst asserted mid-stream -> out_valid stays 0 until new input.
